// File: rtl/scc_mix_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scc_mix_pkg : shared widths and FSM encoding for the volume mixer    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package scc_mix_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Headroom for summing CH_NUM full-scale samples without overflow
  function automatic int acc_w(input int sample_w, input int ch_num);
    return sample_w + clog2(ch_num);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAST = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/scc_volume_mixer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scc_volume_mixer_if : control, sample RAM and mix-result signals     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface scc_volume_mixer_if #(
  parameter int CH_NUM   = 5,
  parameter int SAMPLE_W = 8,
  parameter int VOL_W    = 4,
  parameter int OUT_W    = 11
);
  import scc_mix_pkg::*;
  localparam int IDX_W = clog2(CH_NUM);

  logic                       start;
  logic [IDX_W-1:0]           ch_index;
  logic signed [SAMPLE_W-1:0] sample_in;
  logic [CH_NUM*VOL_W-1:0]    reg_volume;
  logic [CH_NUM-1:0]          reg_enable;
  logic                       busy;
  logic signed [OUT_W-1:0]    mix_out;
  logic                       mix_valid;

  modport master (
    output start, sample_in, reg_volume, reg_enable,
    input  ch_index, busy, mix_out, mix_valid
  );

  modport slave (
    input  start, sample_in, reg_volume, reg_enable,
    output ch_index, busy, mix_out, mix_valid
  );
endinterface
`default_nettype wire

// File: rtl/scc_volume_ramp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scc_volume_ramp : per-channel effective volume, one step per consume |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module scc_volume_ramp
  import scc_mix_pkg::*;
#(
  parameter int CH_NUM = 5,
  parameter int VOL_W  = 4,
  parameter int IDX_W  = clog2(CH_NUM)
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             consume_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [VOL_W-1:0] target_i,
  output logic [VOL_W-1:0] vol_o
);

  logic [VOL_W-1:0] cur_vol_q [CH_NUM];
  logic [VOL_W-1:0] cur_vol_d [CH_NUM];

  always_comb begin
    vol_o = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      cur_vol_d[i] = cur_vol_q[i];
      if (idx_i == IDX_W'(i)) begin
        vol_o = cur_vol_q[i];
        if (consume_i) begin
          if (cur_vol_q[i] < target_i)      cur_vol_d[i] = cur_vol_q[i] + 1'b1;
          else if (cur_vol_q[i] > target_i) cur_vol_d[i] = cur_vol_q[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < CH_NUM; i++) cur_vol_q[i] <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) cur_vol_q[i] <= cur_vol_d[i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/scc_volume_mixer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scc_volume_mixer : time-multiplexed channel scale, sum and saturate  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module scc_volume_mixer
  import scc_mix_pkg::*;
#(
  parameter int CH_NUM   = 5,
  parameter int SAMPLE_W = 8,
  parameter int VOL_W    = 4,
  parameter int OUT_W    = 11,
  parameter bit RAMP_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              nreset,
  scc_volume_mixer_if.slave bus
);

  localparam int IDX_W  = clog2(CH_NUM);
  localparam int ACC_W  = acc_w(SAMPLE_W, CH_NUM);
  localparam int PROD_W = SAMPLE_W + VOL_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CH_NUM - 1);

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           ch_index_q, ch_index_d;
  logic                       cons_q;
  logic [IDX_W-1:0]           cons_idx_q;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [OUT_W-1:0]    mix_out_q, mix_out_d;
  logic                       mix_valid_q, mix_valid_d;

  logic [VOL_W-1:0]           tgt_vol, ramp_vol, vol_used;
  logic                       en_sel;
  logic signed [PROD_W-1:0]   sample_ext, vol_ext;
  logic signed [SAMPLE_W-1:0] scaled, contrib;
  logic signed [ACC_W-1:0]    acc_sum;
  logic signed [OUT_W-1:0]    sat_val;

  // Registers are sampled at the consume cycle so mid-frame writes apply per channel
  always_comb begin
    tgt_vol = '0;
    en_sel  = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (cons_idx_q == IDX_W'(i)) begin
        tgt_vol = bus.reg_volume[i*VOL_W +: VOL_W];
        en_sel  = bus.reg_enable[i];
      end
    end
  end

  scc_volume_ramp #(
    .CH_NUM (CH_NUM),
    .VOL_W  (VOL_W),
    .IDX_W  (IDX_W)
  ) u_ramp (
    .clk       (clk),
    .nreset    (nreset),
    .consume_i (cons_q),
    .idx_i     (cons_idx_q),
    .target_i  (tgt_vol),
    .vol_o     (ramp_vol)
  );

  assign vol_used   = RAMP_EN ? ramp_vol : tgt_vol;
  assign sample_ext = PROD_W'(bus.sample_in);
  assign vol_ext    = PROD_W'({1'b0, vol_used});
  // Arithmetic shift of the signed product floors toward -inf
  assign scaled     = SAMPLE_W'((sample_ext * vol_ext) >>> VOL_W);
  assign contrib    = en_sel ? scaled : '0;
  assign acc_sum    = acc_q + ACC_W'(contrib);

  generate
    if (OUT_W >= ACC_W) begin : g_ext
      assign sat_val = OUT_W'(acc_sum);
    end else begin : g_sat
      localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 <<< (OUT_W - 1)) - 1);
      localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 <<< (OUT_W - 1)));
      always_comb begin
        sat_val = OUT_W'(acc_sum);
        if (acc_sum > SAT_MAX)      sat_val = OUT_W'(SAT_MAX);
        else if (acc_sum < SAT_MIN) sat_val = OUT_W'(SAT_MIN);
      end
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    ch_index_d  = ch_index_q;
    acc_d       = acc_q;
    mix_out_d   = mix_out_q;
    mix_valid_d = 1'b0;
    if (cons_q) acc_d = acc_sum;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_RUN;
          ch_index_d = '0;
          acc_d      = '0;
        end
      end
      ST_RUN: begin
        if (ch_index_q == LAST_IDX) begin
          state_d    = ST_LAST;
          ch_index_d = '0;
        end else begin
          ch_index_d = ch_index_q + 1'b1;
        end
      end
      ST_LAST: begin
        state_d     = ST_IDLE;
        mix_out_d   = sat_val;
        mix_valid_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      ch_index_q  <= '0;
      cons_q      <= 1'b0;
      cons_idx_q  <= '0;
      acc_q       <= '0;
      mix_out_q   <= '0;
      mix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_index_q  <= ch_index_d;
      cons_q      <= (state_q == ST_RUN);
      cons_idx_q  <= ch_index_q;
      acc_q       <= acc_d;
      mix_out_q   <= mix_out_d;
      mix_valid_q <= mix_valid_d;
    end
  end

  assign bus.ch_index  = ch_index_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.mix_out   = mix_out_q;
  assign bus.mix_valid = mix_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_scc_volume_mixer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_scc_volume_mixer : three mixer configurations on shared stimulus  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_scc_volume_mixer;

  localparam int CH = 5;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic start = 1'b0;
  logic signed [7:0] mem [CH];
  logic [3:0] vol [CH];
  logic [CH-1:0] en;
  logic [CH*4-1:0] reg_volume;

  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    reg_volume = '0;
    for (int c = 0; c < CH; c++) reg_volume[c*4 +: 4] = vol[c];
  end

  scc_volume_mixer_if #(.CH_NUM(CH), .SAMPLE_W(8), .VOL_W(4), .OUT_W(11)) if0 ();
  scc_volume_mixer_if #(.CH_NUM(CH), .SAMPLE_W(8), .VOL_W(4), .OUT_W(11)) if1 ();
  scc_volume_mixer_if #(.CH_NUM(CH), .SAMPLE_W(8), .VOL_W(4), .OUT_W(9))  if2 ();

  scc_volume_mixer #(.CH_NUM(CH), .SAMPLE_W(8), .VOL_W(4), .OUT_W(11), .RAMP_EN(1'b0))
    dut0 (.clk(clk), .nreset(nreset), .bus(if0));
  scc_volume_mixer #(.CH_NUM(CH), .SAMPLE_W(8), .VOL_W(4), .OUT_W(11), .RAMP_EN(1'b1))
    dut1 (.clk(clk), .nreset(nreset), .bus(if1));
  scc_volume_mixer #(.CH_NUM(CH), .SAMPLE_W(8), .VOL_W(4), .OUT_W(9), .RAMP_EN(1'b0))
    dut2 (.clk(clk), .nreset(nreset), .bus(if2));

  assign if0.start = start;  assign if1.start = start;  assign if2.start = start;
  assign if0.reg_volume = reg_volume;  assign if1.reg_volume = reg_volume;  assign if2.reg_volume = reg_volume;
  assign if0.reg_enable = en;  assign if1.reg_enable = en;  assign if2.reg_enable = en;

  // Synchronous sample RAM, one per DUT, 1-cycle read latency
  always @(posedge clk) begin
    if0.sample_in <= mem[if0.ch_index];
    if1.sample_in <= mem[if1.ch_index];
    if2.sample_in <= mem[if2.ch_index];
  end

  int busy_a [3], valid_a [3], idx_a [3], out_a [3];
  assign busy_a[0] = int'(if0.busy);      assign busy_a[1] = int'(if1.busy);      assign busy_a[2] = int'(if2.busy);
  assign valid_a[0] = int'(if0.mix_valid); assign valid_a[1] = int'(if1.mix_valid); assign valid_a[2] = int'(if2.mix_valid);
  assign idx_a[0] = int'(if0.ch_index);   assign idx_a[1] = int'(if1.ch_index);   assign idx_a[2] = int'(if2.ch_index);
  assign out_a[0] = if0.mix_out;          assign out_a[1] = if1.mix_out;          assign out_a[2] = if2.mix_out;

  // Frame-level model: phase counter since acceptance, result computed whole-frame
  int  m_p = 0;
  bit  m_valid = 1'b0;
  int  m_out [3] = '{0, 0, 0};
  int  m_cur [3][CH];
  bit  ramp_m [3] = '{1'b0, 1'b1, 1'b0};
  int  ow_m [3] = '{11, 11, 9};

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      m_p = 0;
      m_valid = 1'b0;
      for (int d = 0; d < 3; d++) begin
        m_out[d] = 0;
        for (int c = 0; c < CH; c++) m_cur[d][c] = 0;
      end
    end else begin
      m_valid = 1'b0;
      if (m_p == CH + 1) begin
        for (int d = 0; d < 3; d++) begin
          int sum, v, hi, lo;
          sum = 0;
          for (int c = 0; c < CH; c++) begin
            v = ramp_m[d] ? m_cur[d][c] : int'(vol[c]);
            if (en[c]) sum += (int'(mem[c]) * v) >>> 4;
            if (m_cur[d][c] < int'(vol[c])) m_cur[d][c]++;
            else if (m_cur[d][c] > int'(vol[c])) m_cur[d][c]--;
          end
          hi = (1 << (ow_m[d] - 1)) - 1;
          lo = -(1 << (ow_m[d] - 1));
          m_out[d] = (sum > hi) ? hi : (sum < lo) ? lo : sum;
        end
        m_valid = 1'b1;
        m_p = 0;
      end else if (m_p != 0) begin
        m_p++;
      end else if (start) begin
        m_p = 1;
      end
    end
  end

  task automatic check(input int d, input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL dut%0d %s at cycle %0d: got %0d expected %0d", d, nm, cyc, act, exp);
    end
  endtask

  int last_out [3] = '{0, 0, 0};
  int pv0[$], pc0[$], pv1[$];

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 3; d++) begin
        check(d, "busy", busy_a[d], int'(m_p != 0));
        check(d, "ch_index", idx_a[d], (m_p >= 1 && m_p <= CH) ? m_p - 1 : 0);
        check(d, "mix_valid", valid_a[d], int'(m_valid));
        check(d, "mix_out", out_a[d], m_out[d]);
        if (valid_a[d] != 0) last_out[d] = out_a[d];
      end
      if (valid_a[0] != 0) begin pv0.push_back(out_a[0]); pc0.push_back(cyc); end
      if (valid_a[1] != 0) pv1.push_back(out_a[1]);
    end
  end

  task automatic set_cfg(input int s0, input int s_rest, input int v0, input int v_rest);
    mem[0] = 8'(s0);
    vol[0] = 4'(v0);
    for (int c = 1; c < CH; c++) begin
      mem[c] = 8'(s_rest);
      vol[c] = 4'(v_rest);
    end
  endtask

  task automatic frame();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 nreset = 1'b0;
    @(negedge clk);
    #2 nreset = 1'b1;
  endtask

  initial begin
    int k;
    int seq [11] = '{0, 7, 15, 23, 31, 39, 47, 55, 63, 63, 63};
    en = '1;
    set_cfg(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    check(1, "reset mix_out", out_a[1], 0);
    check(1, "reset busy", busy_a[1], 0);
    @(negedge clk);
    #2 nreset = 1'b1;
    @(negedge clk);

    // 1: single full-scale channel, latency and busy window
    set_cfg(127, 0, 15, 15);
    start = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i == 1) start = 1'b0;
      check(0, "t1 busy", busy_a[0], int'(i >= 1 && i <= 6));
      check(0, "t1 valid", valid_a[0], int'(i == 7));
      if (i == 7) check(0, "t1 mix_out", out_a[0], 119);
      @(negedge clk);
    end

    // 2: negative truncation toward -inf
    set_cfg(-128, 0, 15, 15);
    mem[1] = -8'sd1;
    vol[1] = 4'd1;
    frame();
    check(0, "t2 mix_out", last_out[0], -121);
    check(1, "t2 ramp mix_out", last_out[1], -9);

    // 3: ramp from reset with back-to-back frames
    pulse_reset();
    set_cfg(127, 0, 8, 0);
    pv1.delete();
    @(negedge clk);
    start = 1'b1;
    repeat (77) @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check(1, "t3 frame count", pv1.size(), 11);
    for (int i = 0; i < 11; i++) begin
      if (i < pv1.size()) check(1, "t3 ramp seq", pv1[i], seq[i]);
    end

    // 4: saturation on the narrow output
    set_cfg(127, 127, 15, 15);
    frame();
    check(2, "t4 sat max", last_out[2], 255);
    check(0, "t4 wide max", last_out[0], 595);
    set_cfg(-128, -128, 15, 15);
    frame();
    check(2, "t4 sat min", last_out[2], -256);
    check(0, "t4 wide min", last_out[0], -600);

    // 5: start ignored while busy, accepted in result cycle; disabled channel
    set_cfg(0, 0, 15, 15);
    mem[2] = 8'sd127;
    en = 5'b11011;
    pv0.delete();
    pc0.delete();
    k = cyc;
    for (int i = 0; i <= 17; i++) begin
      start = (i == 0 || i == 2 || i == 4 || i == 7);
      @(negedge clk);
    end
    start = 1'b0;
    check(0, "t5 pulse count", pc0.size(), 2);
    if (pc0.size() == 2) begin
      check(0, "t5 first latency", pc0[0] - k, 7);
      check(0, "t5 second latency", pc0[1] - k, 14);
      check(0, "t5 disabled ch out", pv0[0], 0);
    end
    en = '1;

    // 6: asynchronous reset mid-frame
    set_cfg(127, 0, 8, 0);
    frame();
    check(0, "t6 pre mix_out", last_out[0], 63);
    pv0.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 nreset = 1'b0;
    #1;
    check(0, "t6 abort busy", busy_a[0], 0);
    check(0, "t6 abort ch_index", idx_a[0], 0);
    check(0, "t6 abort mix_out", out_a[0], 0);
    check(1, "t6 abort mix_out", out_a[1], 0);
    @(negedge clk);
    #2 nreset = 1'b1;
    repeat (10) @(negedge clk);
    check(0, "t6 no pulse after abort", pv0.size(), 0);
    frame();
    check(0, "t6 fresh mix_out", last_out[0], 63);
    check(1, "t6 ramp restart", last_out[1], 0);
    frame();
    check(1, "t6 ramp step", last_out[1], 7);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
